acc_pass_ctrl: RTL and testbench

- Sequencer for the 8-lane partial-sum accumulator array (module_acc_1x8). It drives the array's shared address, enable and zero-flag controls.
- A layer result is built over CH input-channel passes. Each pass covers PIX pixel addresses.
- The block accepts one convolution-engine beat per cycle and generates matching read/write addresses with the accumulator's fixed read-to-write latency. It flags final-pass beats as valid layer outputs.

---
 rtl/acc_pkg.sv | 24 ++
 rtl/acc_pass_ctrl_if.sv | 43 ++++
 rtl/acc_ctrl_delay.sv | 51 +++++
 rtl/acc_pass_ctrl.sv | 147 ++++++++++++++
 tb/tb_acc_pass_ctrl.sv | 221 ++++++++++++++++++++++
 5 files changed

// File: rtl/acc_pkg.sv
// Shared types and defaults for the accumulator pass sequencer.
package acc_pkg;

  localparam int ACC_DEPTH    = 114 * 114;
  localparam int ACC_ADDR_BIT = 14;
  localparam int ACC_CH_BIT   = 10;
  localparam int ACC_LAT_DEF  = 2;

  // Sequencer states.
  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_DRAIN = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  // A layer is legal when every pass fits the buffer and is long enough that a
  // pass c+1 read of an address always lands after the pass c write to it.
  function automatic logic cfg_ok(input int pix, input int ch, input int depth,
                                  input int acc_lat);
    return (pix >= 2) && (pix <= depth) && (pix >= acc_lat + 2) && (ch >= 1);
  endfunction

endpackage

// File: rtl/acc_pass_ctrl_if.sv
// Control bus between the conv engine / layer controller and the pass sequencer.
//
// Handshake: a beat transfers in a cycle where in_valid and in_ready are both
// high at the rising clock edge; in_valid without in_ready is dropped, never
// held. in_ready comes from a register, so it never depends on in_valid in the
// same cycle. start, cfg_err and done are single-cycle pulses.
interface acc_pass_ctrl_if
  import acc_pkg::*;
#(
  parameter int ADDR_BIT = ACC_ADDR_BIT,
  parameter int CH_BIT   = ACC_CH_BIT
);
  logic                start;
  logic [ADDR_BIT:0]   cfg_pix;
  logic [CH_BIT-1:0]   cfg_ch;
  logic                in_valid;
  logic                in_zero;
  logic                in_ready;
  logic                read_en;
  logic [ADDR_BIT-1:0] read_addr;
  logic                write_en;
  logic [ADDR_BIT-1:0] write_addr;
  logic                prev_data_zero;
  logic                curr_data_zero;
  logic                out_valid;
  logic                out_last;
  logic                busy;
  logic                done;
  logic                cfg_err;
  state_t              dbg_state;

  modport master (
    output start, cfg_pix, cfg_ch, in_valid, in_zero,
    input  in_ready, read_en, read_addr, write_en, write_addr, prev_data_zero,
           curr_data_zero, out_valid, out_last, busy, done, cfg_err, dbg_state
  );

  modport slave (
    input  start, cfg_pix, cfg_ch, in_valid, in_zero,
    output in_ready, read_en, read_addr, write_en, write_addr, prev_data_zero,
           curr_data_zero, out_valid, out_last, busy, done, cfg_err, dbg_state
  );
endinterface

// File: rtl/acc_ctrl_delay.sv
// Fixed-latency shift register that turns a read-stage beat into its write beat.
module acc_ctrl_delay #(
  parameter int ACC_LAT  = 2,
  parameter int ADDR_BIT = 14
) (
  input  logic                clk_i,
  input  logic                clr_i,
  input  logic                valid_i,
  input  logic [ADDR_BIT-1:0] addr_i,
  input  logic                final_i,
  input  logic                last_i,
  output logic                valid_o,
  output logic [ADDR_BIT-1:0] addr_o,
  output logic                final_o,
  output logic                last_o,
  output logic                pending_o
);

  logic [ACC_LAT-1:0]  valid_q;
  logic [ACC_LAT-1:0]  final_q;
  logic [ACC_LAT-1:0]  last_q;
  logic [ADDR_BIT-1:0] addr_q [ACC_LAT];

  // Shift every stage by one each cycle; clear drops all in-flight writes.
  always_ff @(posedge clk_i) begin
    if (clr_i) begin
      valid_q <= '0;
      final_q <= '0;
      last_q  <= '0;
      for (int i = 0; i < ACC_LAT; i++) addr_q[i] <= '0;
    end else begin
      valid_q[0] <= valid_i;
      final_q[0] <= final_i;
      last_q[0]  <= last_i;
      addr_q[0]  <= addr_i;
      for (int i = 1; i < ACC_LAT; i++) begin
        valid_q[i] <= valid_q[i-1];
        final_q[i] <= final_q[i-1];
        last_q[i]  <= last_q[i-1];
        addr_q[i]  <= addr_q[i-1];
      end
    end
  end

  assign valid_o   = valid_q[ACC_LAT-1];
  assign final_o   = final_q[ACC_LAT-1];
  assign last_o    = last_q[ACC_LAT-1];
  assign addr_o    = addr_q[ACC_LAT-1];
  assign pending_o = |valid_q;

endmodule

// File: rtl/acc_pass_ctrl.sv
// Pass sequencer for the 8-lane partial-sum accumulator: turns conv-engine beats
// into read/write address streams over CH passes of PIX pixels each.
module acc_pass_ctrl
  import acc_pkg::*;
#(
  parameter int DEPTH    = ACC_DEPTH,
  parameter int ADDR_BIT = ACC_ADDR_BIT,
  parameter int CH_BIT   = ACC_CH_BIT,
  parameter int ACC_LAT  = ACC_LAT_DEF
) (
  input logic             clk,
  input logic             rst,
  acc_pass_ctrl_if.slave  bus
);

  state_t              state_q;
  logic [ADDR_BIT-1:0] pix_cnt_q, pix_last_q;
  logic [CH_BIT-1:0]   ch_cnt_q, ch_last_q;
  logic                in_ready_q, busy_q, done_q, cfg_err_q;
  logic                read_en_q, prev_zero_q, curr_zero_q, rd_final_q, rd_last_q;
  logic [ADDR_BIT-1:0] read_addr_q;

  logic                accept_d;
  logic                wr_valid, wr_final, wr_last, dly_pending;
  logic [ADDR_BIT-1:0] wr_addr;

  // Beat transfer; in_ready_q is only ever set while in RUN.
  always_comb begin
    accept_d = bus.in_valid & in_ready_q;
  end

  // Sequencer FSM plus the registered read stage of the pipeline.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      pix_cnt_q   <= '0;
      pix_last_q  <= '0;
      ch_cnt_q    <= '0;
      ch_last_q   <= '0;
      in_ready_q  <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      cfg_err_q   <= 1'b0;
      read_en_q   <= 1'b0;
      read_addr_q <= '0;
      prev_zero_q <= 1'b0;
      curr_zero_q <= 1'b0;
      rd_final_q  <= 1'b0;
      rd_last_q   <= 1'b0;
    end else begin
      done_q    <= 1'b0;
      cfg_err_q <= 1'b0;

      // Read stage: one cycle after the accepted beat.
      read_en_q <= accept_d;
      if (accept_d) begin
        read_addr_q <= pix_cnt_q;
        prev_zero_q <= (ch_cnt_q == '0);
        curr_zero_q <= bus.in_zero;
        rd_final_q  <= (ch_cnt_q == ch_last_q);
        rd_last_q   <= (ch_cnt_q == ch_last_q) && (pix_cnt_q == pix_last_q);
      end else begin
        prev_zero_q <= 1'b0;
        curr_zero_q <= 1'b0;
        rd_final_q  <= 1'b0;
        rd_last_q   <= 1'b0;
      end

      case (state_q)
        S_IDLE: begin
          if (bus.start) begin
            if (cfg_ok(int'(bus.cfg_pix), int'(bus.cfg_ch), DEPTH, ACC_LAT)) begin
              pix_last_q <= ADDR_BIT'(bus.cfg_pix - 1'b1);
              ch_last_q  <= bus.cfg_ch - 1'b1;
              pix_cnt_q  <= '0;
              ch_cnt_q   <= '0;
              in_ready_q <= 1'b1;
              busy_q     <= 1'b1;
              state_q    <= S_RUN;
            end else begin
              cfg_err_q <= 1'b1;
            end
          end
        end
        S_RUN: begin
          if (accept_d) begin
            if (pix_cnt_q == pix_last_q) begin
              pix_cnt_q <= '0;
              if (ch_cnt_q == ch_last_q) begin
                in_ready_q <= 1'b0;
                state_q    <= S_DRAIN;
              end else begin
                ch_cnt_q <= ch_cnt_q + 1'b1;
              end
            end else begin
              pix_cnt_q <= pix_cnt_q + 1'b1;
            end
          end
        end
        S_DRAIN: begin
          // Leave once the read stage and every delay stage are empty.
          if (!read_en_q && !dly_pending) begin
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            state_q <= S_DONE;
          end
        end
        S_DONE: begin
          state_q <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  acc_ctrl_delay #(
    .ACC_LAT  (ACC_LAT),
    .ADDR_BIT (ADDR_BIT)
  ) u_delay (
    .clk_i     (clk),
    .clr_i     (rst),
    .valid_i   (read_en_q),
    .addr_i    (read_addr_q),
    .final_i   (rd_final_q),
    .last_i    (rd_last_q),
    .valid_o   (wr_valid),
    .addr_o    (wr_addr),
    .final_o   (wr_final),
    .last_o    (wr_last),
    .pending_o (dly_pending)
  );

  assign bus.in_ready       = in_ready_q;
  assign bus.read_en        = read_en_q;
  assign bus.read_addr      = read_addr_q;
  assign bus.prev_data_zero = prev_zero_q;
  assign bus.curr_data_zero = curr_zero_q;
  assign bus.write_en       = wr_valid;
  assign bus.write_addr     = wr_addr;
  assign bus.out_valid      = wr_valid & wr_final;
  assign bus.out_last       = wr_valid & wr_last;
  assign bus.busy           = busy_q;
  assign bus.done           = done_q;
  assign bus.cfg_err        = cfg_err_q;
  assign bus.dbg_state      = state_q;

endmodule

// File: tb/tb_acc_pass_ctrl.sv
// Bench for acc_pass_ctrl: directed and random layers against a beat-index model.
module tb_acc_pass_ctrl;
  import acc_pkg::*;

  localparam int LAT   = 2;
  localparam int DEPTH = 114 * 114;
  localparam int MAXC  = 600;

  logic clk;
  logic rst;
  int   total;
  int   bad;

  // Expected per-cycle outputs, indexed by cycle count from the first RUN cycle.
  logic [MAXC+7:0] exp_rd, exp_pz, exp_cz, exp_wr, exp_ov, exp_ol;
  int              exp_ra [MAXC+8];
  logic [13:0]     exp_q[$];

  acc_pass_ctrl_if #(.ADDR_BIT(14), .CH_BIT(10)) bus ();

  acc_pass_ctrl dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // Clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic drive_idle();
    bus.start    = 1'b0;
    bus.cfg_pix  = '0;
    bus.cfg_ch   = '0;
    bus.in_valid = 1'b0;
    bus.in_zero  = 1'b0;
  endtask

  // Checks that the block sits quietly in IDLE with all outputs low.
  task automatic chk_quiet(input string tag);
    chk({tag, " in_ready"}, 32'(bus.in_ready), 0);
    chk({tag, " read_en"}, 32'(bus.read_en), 0);
    chk({tag, " write_en"}, 32'(bus.write_en), 0);
    chk({tag, " out_valid"}, 32'(bus.out_valid), 0);
    chk({tag, " busy"}, 32'(bus.busy), 0);
    chk({tag, " done"}, 32'(bus.done), 0);
    chk({tag, " cfg_err"}, 32'(bus.cfg_err), 0);
    chk({tag, " state"}, 32'(bus.dbg_state), 32'(S_IDLE));
  endtask

  // Rejected start: cfg_err one cycle later, nothing else moves.
  task automatic try_bad(input int pix, input int ch);
    @(posedge clk); #1;
    bus.start = 1'b1; bus.cfg_pix = 15'(pix); bus.cfg_ch = 10'(ch); bus.in_valid = 1'b1;
    @(posedge clk); #1;
    drive_idle();
    bus.in_valid = 1'b1;
    @(negedge clk);
    chk($sformatf("bad pix=%0d ch=%0d cfg_err", pix, ch), 32'(bus.cfg_err), 1);
    chk($sformatf("bad pix=%0d ch=%0d busy", pix, ch), 32'(bus.busy), 0);
    @(posedge clk); #1;
    drive_idle();
    @(negedge clk);
    chk_quiet($sformatf("bad pix=%0d ch=%0d after", pix, ch));
  endtask

  // One full layer. mode 0: in_valid held high, 1: toggling with in_zero on the
  // 2nd beat, 2: random valid/zero. mid_start pulses start while running.
  task automatic run_layer(input int pix, input int ch, input int mode, input bit mid_start);
    int  beats, nb, t_last, k, wi;
    bit  v, z, e_busy, e_done, finished;
    nb = pix * ch;
    beats = 0;
    t_last = -1;
    finished = 1'b0;
    exp_rd = '0; exp_pz = '0; exp_cz = '0; exp_wr = '0; exp_ov = '0; exp_ol = '0;
    for (int i = 0; i < MAXC + 8; i++) exp_ra[i] = 0;
    exp_q.delete();

    // Start cycle; a beat offered here must be ignored.
    @(posedge clk); #1;
    bus.start = 1'b1; bus.cfg_pix = 15'(pix); bus.cfg_ch = 10'(ch);
    bus.in_valid = 1'b1; bus.in_zero = 1'b0;
    @(negedge clk);
    chk("start in_ready", 32'(bus.in_ready), 0);

    for (int c = 0; c < MAXC; c++) begin
      @(posedge clk); #1;
      bus.start = mid_start && (c == 2);
      bus.cfg_pix = bus.start ? 15'd3 : 15'd0;
      bus.cfg_ch  = '0;
      case (mode)
        0:       begin v = 1'b1; z = 1'b0; end
        1:       begin v = (c % 2 == 0); z = v && (beats == 1); end
        default: begin v = ($urandom_range(0, 99) < 65); z = $urandom_range(0, 1) == 1; end
      endcase
      bus.in_valid = v;
      bus.in_zero  = z;
      // Model: the DUT takes beats only while the layer still needs some.
      if (v && beats < nb) begin
        k = beats;
        exp_rd[c+1] = 1'b1;
        exp_ra[c+1] = k % pix;
        exp_pz[c+1] = (k < pix);
        exp_cz[c+1] = z;
        exp_wr[c+1+LAT] = 1'b1;
        exp_ov[c+1+LAT] = (k >= pix * (ch - 1));
        exp_ol[c+1+LAT] = (k == nb - 1);
        exp_q.push_back(14'(k % pix));
        beats++;
        if (beats == nb) t_last = c;
      end
      e_done = (t_last >= 0) && (c == t_last + LAT + 3);
      e_busy = (t_last < 0) || (c < t_last + LAT + 3);
      @(negedge clk);
      chk($sformatf("c%0d in_ready", c), 32'(bus.in_ready), 32'(c == 0 || t_last < 0 || c <= t_last));
      chk($sformatf("c%0d read_en", c), 32'(bus.read_en), 32'(exp_rd[c]));
      if (exp_rd[c]) begin
        chk($sformatf("c%0d read_addr", c), 32'(bus.read_addr), 32'(exp_ra[c]));
        chk($sformatf("c%0d prev_zero", c), 32'(bus.prev_data_zero), 32'(exp_pz[c]));
        chk($sformatf("c%0d curr_zero", c), 32'(bus.curr_data_zero), 32'(exp_cz[c]));
      end
      chk($sformatf("c%0d write_en", c), 32'(bus.write_en), 32'(exp_wr[c]));
      chk($sformatf("c%0d out_valid", c), 32'(bus.out_valid), 32'(exp_ov[c]));
      chk($sformatf("c%0d out_last", c), 32'(bus.out_last), 32'(exp_ol[c]));
      if (bus.write_en === 1'b1) begin
        if (exp_q.size() > 0) begin
          wi = 32'(exp_q.pop_front());
          chk($sformatf("c%0d write_addr", c), 32'(bus.write_addr), 32'(wi));
        end else begin
          chk($sformatf("c%0d unexpected write", c), 32'(bus.write_en), 0);
        end
      end
      chk($sformatf("c%0d busy", c), 32'(bus.busy), 32'(e_busy));
      chk($sformatf("c%0d done", c), 32'(bus.done), 32'(e_done));
      chk($sformatf("c%0d cfg_err", c), 32'(bus.cfg_err), 0);
      if (e_done) begin
        finished = 1'b1;
        break;
      end
    end
    chk($sformatf("layer pix=%0d ch=%0d completed", pix, ch), 32'(finished), 1);
    chk($sformatf("layer pix=%0d ch=%0d writes left", pix, ch), exp_q.size(), 0);
    @(posedge clk); #1;
    drive_idle();
    @(negedge clk);
    chk_quiet($sformatf("layer pix=%0d ch=%0d idle", pix, ch));
  endtask

  // Reset in the middle of a layer after five accepted beats.
  task automatic reset_mid_run();
    @(posedge clk); #1;
    bus.start = 1'b1; bus.cfg_pix = 15'd8; bus.cfg_ch = 10'd2; bus.in_valid = 1'b0;
    for (int c = 0; c < 5; c++) begin
      @(posedge clk); #1;
      bus.start = 1'b0; bus.cfg_pix = '0; bus.cfg_ch = '0; bus.in_valid = 1'b1;
    end
    @(negedge clk);
    chk("pre-reset read_en", 32'(bus.read_en), 1);
    chk("pre-reset busy", 32'(bus.busy), 1);
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk_quiet("post-reset");
    chk("post-reset read_addr", 32'(bus.read_addr), 0);
    chk("post-reset write_addr", 32'(bus.write_addr), 0);
    chk("post-reset out_last", 32'(bus.out_last), 0);
    for (int c = 0; c < 4; c++) begin
      @(posedge clk); #1;
      drive_idle();
      @(negedge clk);
      chk($sformatf("post-reset+%0d write_en", c + 1), 32'(bus.write_en), 0);
      chk($sformatf("post-reset+%0d read_en", c + 1), 32'(bus.read_en), 0);
    end
  endtask

  initial begin
    total = 0;
    bad   = 0;
    rst   = 1'b1;
    drive_idle();
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk_quiet("reset");
    chk("reset read_addr", 32'(bus.read_addr), 0);
    chk("reset write_addr", 32'(bus.write_addr), 0);

    run_layer(4, 1, 0, 1'b0);
    run_layer(4, 3, 0, 1'b0);
    run_layer(4, 2, 1, 1'b0);

    try_bad(3, 1);
    try_bad(4, 0);
    try_bad(DEPTH + 1, 1);
    try_bad(1, 5);

    run_layer(5, 2, 0, 1'b1);
    for (int r = 0; r < 4; r++) begin
      run_layer($urandom_range(4, 9), $urandom_range(1, 3), 2, r[0]);
    end

    reset_mid_run();
    run_layer(4, 1, 0, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
